// File: rtl/rsc_encode.sv
// Rate-1/2 recursive systematic convolutional encoder, memory 2, generators (7,5).
// Encodes a 4-bit word plus 2 trellis-terminating tail bits as 6 coded pairs.
// All outputs are registered. Each edge computes the pair that is shown in the
// following cycle, so the first pair appears the cycle after start is accepted.
module rsc_encode (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data_in,
  output logic       busy,
  output logic       bit_valid,
  output logic       sys_bit,
  output logic       par_bit,
  output logic       enc_done,
  output logic [5:0] cw_sys,
  output logic [5:0] cw_par
);

  typedef enum logic [1:0] {IDLE, ENC, TAIL, DONE} state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;        // index of the step currently on the outputs
  logic [3:0] data_q, data_n;
  logic       s1, s2, s1_n, s2_n;
  logic [5:0] sh_sys, sh_par, sh_sys_n, sh_par_n;
  logic [5:0] cw_sys_n, cw_par_n;
  logic       busy_n, done_n, emit;
  logic       u, a, p, s1_b, s2_b;
  logic [1:0] idx;

  // State, trellis and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      sh_sys    <= '0;
      sh_par    <= '0;
      busy      <= 1'b0;
      bit_valid <= 1'b0;
      sys_bit   <= 1'b0;
      par_bit   <= 1'b0;
      enc_done  <= 1'b0;
      cw_sys    <= '0;
      cw_par    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      data_q    <= data_n;
      s1        <= s1_n;
      s2        <= s2_n;
      sh_sys    <= sh_sys_n;
      sh_par    <= sh_par_n;
      busy      <= busy_n;
      bit_valid <= emit;
      sys_bit   <= emit & u;
      par_bit   <= emit & p;
      enc_done  <= done_n;
      cw_sys    <= cw_sys_n;
      cw_par    <= cw_par_n;
    end
  end

  // Next-state logic and the encoder step for the pair shown next cycle
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    data_n   = data_q;
    s1_b     = s1;
    s2_b     = s2;
    emit     = 1'b0;
    u        = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    cw_sys_n = cw_sys;
    cw_par_n = cw_par;
    idx      = 2'd2 - cnt[1:0];
    case (state)
      IDLE: begin
        if (start) begin
          // Trellis starts from zero; the first step is computed on this edge.
          data_n  = data_in;
          s1_b    = 1'b0;
          s2_b    = 1'b0;
          emit    = 1'b1;
          u       = data_in[3];
          cnt_n   = 3'd0;
          busy_n  = 1'b1;
          state_n = ENC;
        end
      end
      ENC: begin
        emit   = 1'b1;
        busy_n = 1'b1;
        cnt_n  = cnt + 3'd1;
        if (cnt == 3'd3) begin
          u       = s1 ^ s2;       // first tail bit, forces feedback to 0
          state_n = TAIL;
        end else begin
          u = data_q[idx];
        end
      end
      TAIL: begin
        busy_n = 1'b1;
        if (cnt == 3'd4) begin
          emit  = 1'b1;
          u     = s1 ^ s2;
          cnt_n = 3'd5;
        end else begin
          done_n   = 1'b1;
          cw_sys_n = sh_sys;
          cw_par_n = sh_par;
          state_n  = DONE;
        end
      end
      DONE: begin
        cnt_n   = 3'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    a        = u ^ s1_b ^ s2_b;
    p        = a ^ s2_b;
    s1_n     = emit ? a : s1;
    s2_n     = emit ? s1_b : s2;
    sh_sys_n = emit ? {sh_sys[4:0], u} : sh_sys;
    sh_par_n = emit ? {sh_par[4:0], p} : sh_par;
  end

endmodule

// File: tb/tb_rsc_encode.sv
// Self-checking bench for rsc_encode: directed words, start misuse, reset abort,
// and random words compared against a word-level reference of the (7,5) RSC code.
module tb_rsc_encode;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] data_in = '0;
  logic       busy, bit_valid, sys_bit, par_bit, enc_done;
  logic [5:0] cw_sys, cw_par;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int done_cyc;

  rsc_encode dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .bit_valid(bit_valid), .sys_bit(sys_bit), .par_bit(par_bit),
    .enc_done(enc_done), .cw_sys(cw_sys), .cw_par(cw_par)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-level reference: 4 data bits then 2 tail bits that drive feedback to 0.
  function automatic void model(input logic [3:0] w, output logic [5:0] s,
                                output logic [5:0] p, output int fin);
    int r1 = 0, r2 = 0, uu, fb;
    for (int k = 0; k < 6; k++) begin
      uu = (k < 4) ? int'(w[3-k]) : (r1 ^ r2);
      fb = uu ^ r1 ^ r2;
      s[5-k] = uu[0];
      p[5-k] = fb[0] ^ r2[0];
      r2 = r1;
      r1 = fb;
    end
    fin = r1 * 2 + r2;
  endfunction

  // Entered during an IDLE cycle; returns during the IDLE cycle after DONE.
  // hold keeps start high throughout; mid re-pulses start while encoding.
  task automatic encode(input logic [3:0] w, input bit hold, input bit mid);
    logic [5:0] es, ep;
    int fin;
    model(w, es, ep, fin);
    chk("final_state_zero", 8'(fin), 8'd0);
    start   = 1'b1;
    data_in = w;
    tick();
    for (int i = 0; i < 6; i++) begin
      start   = hold | (mid && i == 1);
      data_in = 4'($urandom);
      chk("bit_valid", 8'(bit_valid), 8'd1);
      chk("busy_enc", 8'(busy), 8'd1);
      chk("sys_bit", 8'(sys_bit), 8'(es[5-i]));
      chk("par_bit", 8'(par_bit), 8'(ep[5-i]));
      chk("no_early_done", 8'(enc_done), 8'd0);
      tick();
    end
    chk("enc_done", 8'(enc_done), 8'd1);
    chk("valid_off_done", 8'(bit_valid), 8'd0);
    chk("sys_zero_done", 8'({sys_bit, par_bit}), 8'd0);
    chk("busy_done", 8'(busy), 8'd1);
    chk("cw_sys", 8'(cw_sys), 8'(es));
    chk("cw_par", 8'(cw_par), 8'(ep));
    done_cyc = cyc;
    tick();
    chk("done_pulse_end", 8'(enc_done), 8'd0);
    chk("busy_idle", 8'(busy), 8'd0);
    chk("valid_idle", 8'(bit_valid), 8'd0);
    chk("cw_sys_hold", 8'(cw_sys), 8'(es));
    chk("cw_par_hold", 8'(cw_par), 8'(ep));
  endtask

  initial begin
    int prev_done;
    logic [3:0] w;
    bit seen_done;

    // Reset state
    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_valid", 8'(bit_valid), 8'd0);
    chk("rst_bits", 8'({sys_bit, par_bit, enc_done}), 8'd0);
    chk("rst_cw", 8'({cw_sys[1:0], cw_par}), 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed words, including absolute expectations for 1011
    encode(4'b1011, 1'b0, 1'b0);
    chk("abs_cw_sys_1011", 8'(cw_sys), 8'b0010_1101);
    chk("abs_cw_par_1011", 8'(cw_par), 8'b0011_0011);
    encode(4'b1000, 1'b0, 1'b0);
    chk("abs_cw_sys_1000", 8'(cw_sys), 8'b0010_0011);
    chk("abs_cw_par_1000", 8'(cw_par), 8'b0011_1001);
    encode(4'b0000, 1'b0, 1'b0);

    // Start pulsed during ENC: ignored, exactly one word
    encode(4'b1011, 1'b0, 1'b1);
    tick();
    chk("mid_start_ignored", 8'(busy), 8'd0);

    // Start held: back-to-back words, DONE pulses 8 cycles apart
    encode(4'b1011, 1'b1, 1'b0);
    prev_done = done_cyc;
    encode(4'b1000, 1'b0, 1'b0);
    chk("b2b_spacing", 8'(done_cyc - prev_done), 8'd8);

    // Reset during the third bit_valid cycle aborts the word
    start   = 1'b1;
    data_in = 4'b1011;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", 8'(bit_valid), 8'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 8'(bit_valid), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_bits", 8'({sys_bit, par_bit, enc_done}), 8'd0);
    chk("arst_cw", 8'({cw_sys[1:0], cw_par}), 8'd0);
    chk("arst_cw_hi", 8'(cw_sys), 8'd0);
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (enc_done) seen_done = 1'b1;
      tick();
    end
    chk("abort_no_done", 8'(seen_done), 8'd0);
    encode(4'b0110, 1'b0, 1'b0);

    // Start on the first edge after reset release
    rst = 1'b1;
    tick();
    rst = 1'b0;
    encode(4'b1101, 1'b0, 1'b0);

    // Random words with random held/mid start
    for (int n = 0; n < 12; n++) begin
      w = 4'($urandom);
      encode(w, 1'($urandom), 1'($urandom));
    end
    start = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
